cla_nibble_serial_adder: RTL and testbench
==========================================

// Module: cla_nibble_serial_adder
// PURPOSE
//  Upstream sequencer for the registered 4-bit CarryLA_4 adder stage. Accepts WIDTH-bit operand pairs
//  over a valid/ready handshake, slices them into 4-bit nibbles, and feeds one nibble per cycle to CarryLA_4.
//  Chains each nibble's carry-out into the next nibble. Reassembles the WIDTH-bit sum with carry-out and
//  signed overflow, then presents the result on a valid/ready output.
// PARAMETERS
//  WIDTH    16   operand/sum width; must be a multiple of 4 and >= 8
//  NIBBLES  WIDTH/4  derived localparam, not overridable; number of nibble cycles per operation
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand pair a/b/cin is valid
//  in_ready   out  1      block can accept an operand pair
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in to nibble 0
//  out_valid  out  1      sum/cout/ovf are valid
//  out_ready  in   1      consumer accepts the result
//  sum        out  WIDTH  a+b+cin, modulo 2^WIDTH
//  cout       out  1      carry-out of the MSB nibble
//  ovf        out  1      two's-complement overflow
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready: latch a, b; carry_q<=cin; idx<=0; go to RUN.
//  - RUN: CarryLA_4 combinationally adds a_q[idx], b_q[idx], carry_q.
//    Each edge: sum_q[idx]<=nibble sum; carry_q<=nibble cout; idx<=idx+1.
//    On the edge with idx==NIBBLES-1, go to DONE instead.
//  - DONE: out_valid=1. sum, cout=carry_q, ovf are stable. On out_ready, go to IDLE.
//  Latency: out_valid rises exactly NIBBLES cycles after the accept edge (4 for WIDTH=16).
//  Throughput: one operation per NIBBLES+2 cycles with out_ready tied high.
//  ovf = (a_q[MSB]==b_q[MSB]) && (sum_q[MSB]!=a_q[MSB]); registered with sum.
//  in_ready=0 in RUN and DONE; in_valid is ignored there, and operands are not re-sampled.
//  out_ready while out_valid=0 has no effect. No bypass: the next accept is possible one cycle after the output handshake.
//  sum, cout and ovf keep their last values after the output handshake; only out_valid qualifies them.
//  Reset (any time, including mid-RUN): state=IDLE, idx=0. All registers and outputs 0:
//    sum=0, cout=0, ovf=0, out_valid=0, busy=0. in_ready=1 from the first edge after rst_n deasserts.
//    Any partial result is discarded.
// CONFIGURATION
//  SUBTRACT_EN defined:
//    - Adds input port `sub` (1b), sampled at accept.
//    - When sub=1: b_q<=~b and carry_q<=1, so the result is a-b.
//    - cout=1 means no borrow. ovf uses the inverted b_q MSB.
//  SUBTRACT_EN undefined: port `sub` is absent; the block is add-only.
// STRUCTURE
//  Shared package cla_pkg: NIBBLE_W=4, FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), nibble-index width function.
//  Sub-module: one CarryLA_4 instance (a,b,cin,sum,cout) as the nibble adder.
//    No extra D flip-flops around it; this block's registers provide the staging.
// TESTING (WIDTH=16)
//  1. 0x1234+0x4321, cin=0 -> sum=0x5555, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
//  2. 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; the carry propagates through all 4 nibbles.
//  3. 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1. Then 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1.
//  4. Backpressure: out_ready=0 for 5 cycles in DONE -> sum/cout/ovf stable, in_ready=0;
//     a new in_valid with 0x0001+0x0001 is not accepted until after the out_ready handshake.
//  5. Reset pulse 2 cycles into RUN -> all outputs 0, in_ready=1 after release;
//     the next op 0x0F0F+0x00F1 -> 0x1000, cout=0.
//  6. SUBTRACT_EN: 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0; 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.

Source files
------------

// File: rtl/cla_nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial carry-lookahead adder: nibble width, FSM encoding, index sizing.
package cla_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int idx_w(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/cla_nibble_serial_adder_if.sv
// Operand/result handshake bundle for cla_nibble_serial_adder.
// Optional `sub` signal exists only when SUBTRACT_EN is defined.
interface cla_nibble_serial_adder_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SUBTRACT_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef SUBTRACT_EN
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`endif

endinterface

// File: rtl/cla_nibble_serial_adder_cla4.sv
// Purely combinational 4-bit carry-lookahead adder used as the nibble engine.
module CarryLA_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p, g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Carries expanded from generate/propagate terms, no ripple chain
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// Sequences WIDTH-bit add operations through one CarryLA_4, one nibble per cycle.
// Define SUBTRACT_EN to add the `sub` input (a-b via inverted b and forced carry-in).
module cla_nibble_serial_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cla_nibble_serial_adder_if.slave bus,
    output logic                     busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_w(NIBBLES);
    localparam int MSB     = WIDTH - 1;

    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                carry_q, carry_d, ovf_q, ovf_d;
    logic                init_q;

    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
    logic                nib_cout;
    logic                accept;

    assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

    CarryLA_4 u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // init_q holds in_ready low until the first edge after reset release
    assign bus.in_ready  = (state_q == ST_IDLE) && init_q;
    assign bus.out_valid = (state_q == ST_DONE);
    assign busy          = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = carry_q;
    assign bus.ovf       = ovf_q;
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = bus.a;
`ifdef SUBTRACT_EN
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1   : bus.cin;
`else
                    b_d     = bus.b;
                    carry_d = bus.cin;
`endif
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum;
                carry_d = nib_cout;
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    // nib_sum MSB is the final sum MSB on the last nibble
                    ovf_d   = (a_q[MSB] == b_q[MSB]) && (nib_sum[NIBBLE_W-1] != a_q[MSB]);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            init_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Randomized self-checking bench for cla_nibble_serial_adder (WIDTH=16), arithmetic reference model.
// Subtract cases run when SUBTRACT_EN is defined.
module tb_cla_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cla_nibble_serial_adder_if #(.WIDTH(W)) bus ();

    cla_nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic c,
                                  input logic s, output logic [15:0] sm, output logic co,
                                  output logic ov);
        int ua, ub, sa, sb, r;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            r  = ua - ub;
            sm = r[15:0];
            co = (ua >= ub);
            r  = sa - sb;
        end else begin
            r  = ua + ub + int'(c);
            sm = r[15:0];
            co = (r > 65535);
            r  = sa + sb + int'(c);
        end
        ov = (r > 32767) || (r < -32768);
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic s, input int hold, input bit poke);
        logic [15:0] es;
        logic        ec, eo;
        int          n, lat;
        model(a, b, c, s, es, ec, eo);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = c;
`ifdef SUBTRACT_EN
        bus.sub = s;
`endif
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 20), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        chk("busy_run", 32'(busy), 32'd1);
        chk("in_ready_run", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, NIB);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                bus.in_valid = 1'b1;
                bus.a = 16'h0001;
                bus.b = 16'h0001;
            end
            chk("bp_sum", 32'(bus.sum), 32'(es));
            chk("bp_cout", 32'(bus.cout), 32'(ec));
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("sum", 32'(bus.sum), 32'(es));
        chk("cout", 32'(bus.cout), 32'(ec));
        chk("ovf", 32'(bus.ovf), 32'(eo));
        chk("busy_done", 32'(busy), 32'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("valid_clr", 32'(bus.out_valid), 32'd0);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        chk("sum_kept", 32'(bus.sum), 32'(es));
        chk("ovf_kept", 32'(bus.ovf), 32'(eo));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b0;
`ifdef SUBTRACT_EN
        bus.sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 5, 1'b1);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

        // Reset two cycles into RUN discards the partial result
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 16'h1234;
        bus.b = 16'h1111;
        bus.cin = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", 32'(bus.sum), 32'd0);
        chk("mid_rst_cout", 32'(bus.cout), 32'd0);
        chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, 1'b0);

`ifdef SUBTRACT_EN
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1, 1'b0);
`endif

        for (int k = 0; k < 40; k++) begin
            logic s;
`ifdef SUBTRACT_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            run_op(16'($urandom), 16'($urandom), 1'($urandom), s,
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
